move_commit: RTL

- Initiator side of the board-write port: converts one accepted chess move (from-square, to-square) into the sequence of single-square write commands on the 11-bit change-piece bus consumed by build_board.
- Reads the current 256-bit board snapshot once, at accept time.
- Handles normal moves, captures, pawn promotion to queen, and castling (two extra rook writes).
- Sits between the game-logic move validator and build_board.

---
 rtl/chess_pkg.sv | 57 +++++
 rtl/move_classify.sv | 46 ++++
 rtl/move_commit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/chess_pkg.sv
// Shared chess encodings for the board-write path.
// Contents: colour and piece-type codes, change-piece bus field positions,
// move_commit FSM state type, square-index helpers.
package chess_pkg;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    KING   = 3'd1,
    QUEEN  = 3'd2,
    BISHOP = 3'd3,
    KNIGHT = 3'd4,
    ROOK   = 3'd5,
    PAWN   = 3'd6
  } piece_type_e;

  // changePiece = {write_en, piece[3:0], square[5:0]}
  localparam int unsigned CP_W         = 11;
  localparam int unsigned CP_EN_BIT    = 10;
  localparam int unsigned CP_PIECE_LSB = 6;
  localparam int unsigned CP_SQ_LSB    = 0;

  typedef enum logic [2:0] {
    StIdle,
    StWrDst,
    StWrSrc,
    StRkDst,
    StRkSrc,
    StDone,
    StErr
  } move_state_e;

  // Square s = col*8 + row.
  function automatic logic [2:0] sq_col(input logic [5:0] s);
    return s[5:3];
  endfunction

  function automatic logic [2:0] sq_row(input logic [5:0] s);
    return s[2:0];
  endfunction

  function automatic logic [5:0] sq_make(input logic [2:0] col, input logic [2:0] row);
    return {col, row};
  endfunction

  function automatic logic [CP_W-1:0] cp_write(input logic [3:0] piece, input logic [5:0] sq);
    logic [CP_W-1:0] w;
    w                      = '0;
    w[CP_EN_BIT]           = 1'b1;
    w[CP_PIECE_LSB +: 4]   = piece;
    w[CP_SQ_LSB +: 6]      = sq;
    return w;
  endfunction

endpackage

// File: rtl/move_classify.sv
// Combinational move classifier.
// Ports:
//   i_piece      piece on the source square {colour, type}
//   i_from/i_to  source / destination squares
//   o_dst_piece  piece to write on the destination (queen on promotion)
//   o_is_castle  king castling move; rook must be relocated
//   o_rook_from  rook source square (valid when o_is_castle)
//   o_rook_to    rook destination square (valid when o_is_castle)
//   o_reject     null move or empty source
module move_classify
  import chess_pkg::*;
#(
  parameter bit CASTLE_EN  = 1'b1,
  parameter bit PROMOTE_EN = 1'b1
) (
  input  logic [3:0] i_piece,
  input  logic [5:0] i_from,
  input  logic [5:0] i_to,
  output logic [3:0] o_dst_piece,
  output logic       o_is_castle,
  output logic [5:0] o_rook_from,
  output logic [5:0] o_rook_to,
  output logic       o_reject
);

  logic w_promote;
  logic w_kingside;

  always_comb begin
    // White promotes on row 0, black on row 7.
    w_promote = PROMOTE_EN && (i_piece[2:0] == PAWN) &&
                (((i_piece[3] == WHITE) && (sq_row(i_to) == 3'd0)) ||
                 ((i_piece[3] == BLACK) && (sq_row(i_to) == 3'd7)));
    o_dst_piece = w_promote ? {i_piece[3], QUEEN} : i_piece;

    w_kingside  = (sq_col(i_to) == 3'd6);
    o_is_castle = CASTLE_EN && (i_piece[2:0] == KING) &&
                  (sq_row(i_from) == sq_row(i_to)) && (sq_col(i_from) == 3'd4) &&
                  (w_kingside || (sq_col(i_to) == 3'd2));
    o_rook_from = sq_make(w_kingside ? 3'd7 : 3'd0, sq_row(i_from));
    o_rook_to   = sq_make(w_kingside ? 3'd5 : 3'd3, sq_row(i_from));

    o_reject = (i_from == i_to) || (i_piece[2:0] == EMPTY);
  end

endmodule

// File: rtl/move_commit.sv
// Turns one accepted move into single-square writes on the change-piece bus.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   boardPass     256-bit board snapshot, sampled only at accept
//   move_valid    move request; move_from / move_to its squares
//   move_ready    high only in idle
//   changePiece   registered {write_en, piece[3:0], square[5:0]}
//   move_done     one-cycle pulse after the last write
//   move_err      one-cycle pulse on a rejected move
//   captured      piece previously on the destination, valid with move_done
module move_commit
  import chess_pkg::*;
#(
  parameter bit CASTLE_EN  = 1'b1,
  parameter bit PROMOTE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [255:0]    boardPass,
  input  logic            move_valid,
  input  logic [5:0]      move_from,
  input  logic [5:0]      move_to,
  output logic            move_ready,
  output logic [CP_W-1:0] changePiece,
  output logic            move_done,
  output logic            move_err,
  output logic [3:0]      captured
);

  move_state_e     r_state;
  logic [5:0]      r_from;
  logic            r_castle;
  logic [3:0]      r_rook_piece;
  logic [5:0]      r_rook_from;
  logic [5:0]      r_rook_to;
  logic [3:0]      r_cap;
  logic [CP_W-1:0] r_change;
  logic            r_done;
  logic            r_err;
  logic [3:0]      r_captured;

  logic [3:0] w_p;
  logic [3:0] w_c;
  logic [3:0] w_dst_piece;
  logic       w_is_castle;
  logic [5:0] w_rook_from;
  logic [5:0] w_rook_to;
  logic       w_reject;

  assign w_p = boardPass[{move_from, 2'b00} +: 4];
  assign w_c = boardPass[{move_to, 2'b00} +: 4];

  move_classify #(
    .CASTLE_EN  (CASTLE_EN),
    .PROMOTE_EN (PROMOTE_EN)
  ) u_classify (
    .i_piece     (w_p),
    .i_from      (move_from),
    .i_to        (move_to),
    .o_dst_piece (w_dst_piece),
    .o_is_castle (w_is_castle),
    .o_rook_from (w_rook_from),
    .o_rook_to   (w_rook_to),
    .o_reject    (w_reject)
  );

  // Outputs are loaded together with the next state, so each write is
  // visible during the state that names it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_from       <= '0;
      r_castle     <= 1'b0;
      r_rook_piece <= '0;
      r_rook_from  <= '0;
      r_rook_to    <= '0;
      r_cap        <= '0;
      r_change     <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_captured   <= '0;
    end else begin
      r_change <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (move_valid) begin
            if (w_reject) begin
              r_state <= StErr;
              r_err   <= 1'b1;
            end else begin
              r_state      <= StWrDst;
              r_from       <= move_from;
              r_castle     <= w_is_castle;
              r_rook_piece <= {w_p[3], ROOK};
              r_rook_from  <= w_rook_from;
              r_rook_to    <= w_rook_to;
              r_cap        <= w_c;
              r_change     <= cp_write(w_dst_piece, move_to);
            end
          end
        end
        StWrDst: begin
          r_state  <= StWrSrc;
          r_change <= cp_write(4'b0000, r_from);
        end
        StWrSrc: begin
          if (r_castle) begin
            r_state  <= StRkDst;
            r_change <= cp_write(r_rook_piece, r_rook_to);
          end else begin
            r_state    <= StDone;
            r_done     <= 1'b1;
            r_captured <= r_cap;
          end
        end
        StRkDst: begin
          r_state  <= StRkSrc;
          r_change <= cp_write(4'b0000, r_rook_from);
        end
        StRkSrc: begin
          r_state    <= StDone;
          r_done     <= 1'b1;
          r_captured <= r_cap;
        end
        StDone:  r_state <= StIdle;
        StErr:   r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign move_ready  = (r_state == StIdle);
  assign changePiece = r_change;
  assign move_done   = r_done;
  assign move_err    = r_err;
  assign captured    = r_captured;

endmodule
